// File: rtl/multhub_pipe_if.sv
// Operand/result stream bundle for multhub_pipe: valid/ready operand pair in, valid/ready product out.
interface multhub_pipe_if #(
    parameter int unsigned M = 23,
    parameter int unsigned E = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [E+M:0] x;
    logic [E+M:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [E+M:0] z;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/multhub_pipe.sv
// Pipelined HUB floating-point multiplier with valid/ready stream and STAGES-cycle latency.
// Define MULTHUB_FLAGS_EN to add sticky overflow/underflow/NaN flags with a clear input.
module multhub_pipe #(
    parameter int unsigned M      = 23,
    parameter int unsigned E      = 8,
    parameter int unsigned BIAS   = 127,
    parameter int unsigned STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    multhub_pipe_if.slave  bus
`ifdef MULTHUB_FLAGS_EN
    ,
    input  logic           flag_clr,
    output logic           flag_ovf,
    output logic           flag_udf,
    output logic           flag_nan
`endif
);
    localparam int unsigned W  = E + M + 1;
    localparam int unsigned SW = M + 2;
    localparam int unsigned PW = 2 * M + 4;
    localparam logic [E+1:0] BiasW = (E+2)'(BIAS);

    if (STAGES < 1 || STAGES > 4) begin : gen_bad_stages
        $error("multhub_pipe: STAGES must be in 1..4");
    end

    logic          sx, sy, sz;
    logic [E-1:0]  ex, ey;
    logic [M-1:0]  mx, my, mz;
    logic [SW-1:0] sig_x, sig_y;
    logic [PW-1:0] prod;
    logic [E+1:0]  ez;
    logic          x_inf, y_inf, x_zero, y_zero;
    logic          is_nan, is_inf, is_zero, ez_ovf, ez_udf;
    logic [W-1:0]  res_d;
    logic          unused_prod_lsbs;

    assign {sx, ex, mx} = bus.x;
    assign {sy, ey, my} = bus.y;
    assign sz = sx ^ sy;

    // Implicit leading 1 and implicit LSB of 1 on both significands.
    assign sig_x = {1'b1, mx, 1'b1};
    assign sig_y = {1'b1, my, 1'b1};
    assign prod  = sig_x * sig_y;
    assign unused_prod_lsbs = ^prod[M+1:0];

    assign mz = prod[PW-1] ? prod[PW-2:M+3] : prod[PW-3:M+2];
    assign ez = {2'b00, ex} + {2'b00, ey} + (E+2)'(prod[PW-1]) - BiasW;

    assign x_inf   = &ex;
    assign y_inf   = &ey;
    assign x_zero  = ~|ex;
    assign y_zero  = ~|ey;
    assign is_nan  = (x_inf && y_zero) || (y_inf && x_zero);
    assign is_inf  = x_inf || y_inf;
    assign is_zero = x_zero || y_zero;
    // ez is signed in E+2 bits; bit E+1 is the sign.
    assign ez_ovf  = !ez[E+1] && (ez[E:0] >= {1'b0, {E{1'b1}}});
    assign ez_udf  = ez[E+1] || (ez == '0);

    always_comb begin
        res_d = '0;
        if (is_nan) begin
            res_d = {sz, {E{1'b1}}, {M{1'b1}}};
        end else if (is_inf || (!is_zero && ez_ovf)) begin
            res_d = {sz, {E{1'b1}}, {M{1'b0}}};
        end else if (is_zero || ez_udf) begin
            res_d = {sz, {(E+M){1'b0}}};
        end else begin
            res_d = {sz, ez[E-1:0], mz};
        end
    end

    logic [STAGES-1:0] vld_q;
    logic [W-1:0]      res_q [STAGES];
    logic              adv;

    assign adv           = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = rst_n && adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.z         = res_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= bus.in_valid;
            res_q[0] <= res_d;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
            end
        end
    end

`ifdef MULTHUB_FLAGS_EN
    // Per-result condition bits {nan, ovf, udf} travel alongside the data.
    logic [2:0] cond_d;
    logic [2:0] cond_q [STAGES];
    logic [2:0] flags_q;
    logic [2:0] flag_set;

    assign cond_d[2] = is_nan;
    assign cond_d[1] = !is_inf && !is_zero && ez_ovf;
    assign cond_d[0] = !is_inf && !is_zero && ez_udf;

    assign flag_set = (bus.out_valid && bus.out_ready) ? cond_q[STAGES-1] : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                cond_q[i] <= '0;
            end
        end else begin
            flags_q <= flag_set | (flags_q & {3{!flag_clr}});
            if (adv) begin
                cond_q[0] <= cond_d;
                for (int i = 1; i < STAGES; i++) begin
                    cond_q[i] <= cond_q[i-1];
                end
            end
        end
    end

    assign flag_nan = flags_q[2];
    assign flag_ovf = flags_q[1];
    assign flag_udf = flags_q[0];
`endif
endmodule
